// File: rtl/qcldpc_enc_scheduler.sv
// Sequencing controller for the QC-LDPC encoder: accepts one codeword of info blocks,
// walks the prototype-matrix shift ROM and steers the rotate/accumulate datapath.
module qcldpc_enc_scheduler #(
  parameter int unsigned NUM_OF_SUPPORTED_Z           = 3,
  parameter int unsigned NUM_INFO_BLKS_PER_CODE_BLK   = 20,
  parameter int unsigned NUM_PARITY_BLKS_PER_CODE_BLK = 4,
  parameter int unsigned ROM_LATENCY                  = 1,
  localparam int unsigned IB    = NUM_INFO_BLKS_PER_CODE_BLK,
  localparam int unsigned NP    = NUM_PARITY_BLKS_PER_CODE_BLK,
  localparam int unsigned ZBLK  = (IB + NP) * NP,
  localparam int unsigned ADDRW = $clog2(ZBLK * NUM_OF_SUPPORTED_Z),
  localparam int unsigned ZW    = (NUM_OF_SUPPORTED_Z > 1) ? $clog2(NUM_OF_SUPPORTED_Z) : 1,
  localparam int unsigned PW    = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_OF_SUPPORTED_Z-1:0] req_z,
  output logic                          busy,
  output logic                          cfg_err,
  output logic [ZW-1:0]                 z_idx,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [ADDRW-1:0]              rom_addr,
  output logic                          acc_clr,
  output logic                          acc_en,
  output logic                          par_en,
  output logic [PW-1:0]                 par_idx,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned CW = (IB > 1) ? $clog2(IB) : 1;
  localparam int unsigned DW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_PARITY, S_DRAIN, S_OUT} state_t;

  typedef struct packed {
    logic          acc_clr;
    logic          acc_en;
    logic          par_en;
    logic [PW-1:0] par_idx;
  } pipe_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [PW-1:0]   par_q, par_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [ZW-1:0]   z_idx_q, z_idx_d;
  logic            cfg_err_q, cfg_err_d;
  logic [ZW-1:0]   req_idx;
  logic [ADDRW-1:0] base;
  pipe_t           push, pipe_out;

  // Index of the (assumed single) set bit of req_z.
  always_comb begin
    req_idx = '0;
    for (int unsigned i = 0; i < NUM_OF_SUPPORTED_Z; i++) begin
      if (req_z[i]) req_idx = ZW'(i);
    end
  end

  assign base = ADDRW'(z_idx_q) * ADDRW'(ZBLK);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      par_q     <= '0;
      drn_q     <= '0;
      z_idx_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      par_q     <= par_d;
      drn_q     <= drn_d;
      z_idx_q   <= z_idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    par_d     = par_q;
    drn_d     = drn_q;
    z_idx_d   = z_idx_q;
    cfg_err_d = 1'b0;
    push      = '0;
    in_ready  = 1'b0;
    rom_addr  = '0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ($onehot(req_z)) begin
            z_idx_d = req_idx;
            col_d   = '0;
            state_d = S_ACCUM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        rom_addr = base + ADDRW'(col_q) * ADDRW'(NP);
        if (in_valid) begin
          push.acc_en  = 1'b1;
          push.acc_clr = (col_q == '0);
          if (col_q == CW'(IB - 1)) begin
            par_d   = '0;
            state_d = S_PARITY;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_PARITY: begin
        rom_addr     = base + (ADDRW'(IB) + ADDRW'(par_q)) * ADDRW'(NP);
        push.par_en  = 1'b1;
        push.par_idx = par_q;
        if (par_q == PW'(NP - 1)) begin
          drn_d   = '0;
          state_d = (ROM_LATENCY == 0) ? S_OUT : S_DRAIN;
        end else begin
          par_d = par_q + PW'(1);
        end
      end
      S_DRAIN: begin
        // Flush the ROM-latency pipe so the last parity step lands before out_valid.
        if (drn_q == DW'(ROM_LATENCY - 1)) begin
          state_d = S_OUT;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control delay line that aligns datapath enables with ROM read data.
  generate
    if (ROM_LATENCY == 0) begin : g_lut
      assign pipe_out = push;
    end else begin : g_bram
      pipe_t pipe_q [ROM_LATENCY];
      pipe_t pipe_d [ROM_LATENCY];
      always_comb begin
        pipe_d[0] = push;
        for (int unsigned i = 1; i < ROM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end
      assign pipe_out = pipe_q[ROM_LATENCY-1];
    end
  endgenerate

  assign busy    = (state_q != S_IDLE);
  assign cfg_err = cfg_err_q;
  assign z_idx   = z_idx_q;
  assign acc_clr = pipe_out.acc_clr;
  assign acc_en  = pipe_out.acc_en;
  assign par_en  = pipe_out.par_en;
  assign par_idx = pipe_out.par_idx;

endmodule

// File: tb/tb_qcldpc_enc_scheduler.sv
// Bench for qcldpc_enc_scheduler: BRAM (latency 1) and LUT (latency 0) builds share stimulus
// and are checked every cycle against a beat-counting model of the encode sequence.
module tb_qcldpc_enc_scheduler;

  localparam int IB = 20;
  localparam int NP = 4;
  localparam int ZBLK = 96;

  logic clk, rst_n, start, in_valid, out_ready;
  logic [2:0] req_z;

  logic busy1, cfg1, ir1, clr1, aen1, pen1, ov1;
  logic [1:0] zi1, pi1;
  logic [8:0] ra1;
  logic busy0, cfg0, ir0, clr0, aen0, pen0, ov0;
  logic [1:0] zi0, pi0;
  logic [8:0] ra0;

  logic [19:0] obs1, obs0;
  assign obs1 = {cfg1, busy1, ir1, ov1, aen1, clr1, pen1, pi1, zi1, ra1};
  assign obs0 = {cfg0, busy0, ir0, ov0, aen0, clr0, pen0, pi0, zi0, ra0};

  int nchk, nerr;

  qcldpc_enc_scheduler #(.ROM_LATENCY(1)) dut1 (
    .CLK(clk), .rst_n(rst_n), .start(start), .req_z(req_z), .busy(busy1), .cfg_err(cfg1),
    .z_idx(zi1), .in_valid(in_valid), .in_ready(ir1), .rom_addr(ra1), .acc_clr(clr1),
    .acc_en(aen1), .par_en(pen1), .par_idx(pi1), .out_valid(ov1), .out_ready(out_ready));

  qcldpc_enc_scheduler #(.ROM_LATENCY(0)) dut0 (
    .CLK(clk), .rst_n(rst_n), .start(start), .req_z(req_z), .busy(busy0), .cfg_err(cfg0),
    .z_idx(zi0), .in_valid(in_valid), .in_ready(ir0), .rom_addr(ra0), .acc_clr(clr0),
    .acc_en(aen0), .par_en(pen0), .par_idx(pi0), .out_valid(ov0), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // One codeword: start at t=0, random in_valid with pv% density, optional out_ready stall
  // of 'hold' cycles once both builds present out_valid, optional start held high while busy.
  task automatic run_encode(input int z, input int pv, input int hold, input bit poke,
                            output int n_acc, output int n_par);
    int beats, t, pstart, pend;
    bit done0, done1;
    logic [8:0] base, addr;
    logic ir;
    logic [4:0] ev, ev_prev;
    logic [19:0] exp0, exp1;
    n_acc = 0; n_par = 0; beats = 0; pstart = 0; pend = 1 << 30;
    ev_prev = '0; done0 = 0; done1 = 0; t = 0;
    base = 9'(z * ZBLK);
    @(negedge clk);
    start = 1'b1; req_z = 3'(1 << z); in_valid = 1'($urandom_range(1)); out_ready = 1'b0;
    #1;
    nchk++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      nerr++; $display("FAIL start_idle: busy0=%b busy1=%b required 0", busy0, busy1);
    end
    while (!(done0 && done1) && t < 300) begin
      t++;
      @(negedge clk);
      start = poke;
      req_z = poke ? 3'(1 << $urandom_range(2)) : 3'($urandom_range(7));
      in_valid = ($urandom_range(99) < pv);
      out_ready = (hold == 0) ? 1'b1 : (t >= pend + 1 + hold);
      ir = 1'b0; addr = '0; ev = '0;
      if (beats < IB) begin
        ir = 1'b1;
        addr = base + 9'(beats * NP);
        if (in_valid) begin
          ev = {1'b1, beats == 0, 1'b0, 2'b00};
          beats++;
          if (beats == IB) begin pstart = t + 1; pend = t + 1 + NP; end
        end
      end else if (t < pend) begin
        addr = base + 9'((IB + t - pstart) * NP);
        ev = {2'b00, 1'b1, 2'(t - pstart)};
      end
      exp0 = {1'b0, !done0, ir, (t >= pend) && !done0, ev, 2'(z), addr};
      exp1 = {1'b0, !done1, ir, (t >= pend + 1) && !done1, ev_prev, 2'(z), addr};
      #1;
      nchk++;
      if (obs0 !== exp0) begin
        nerr++; $display("FAIL lut_cycle z=%0d t=%0d: got %h required %h", z, t, obs0, exp0);
      end
      nchk++;
      if (obs1 !== exp1) begin
        nerr++; $display("FAIL bram_cycle z=%0d t=%0d: got %h required %h", z, t, obs1, exp1);
      end
      n_acc += int'(aen1);
      n_par += int'(pen1);
      if (out_ready && t >= pend && !done0) done0 = 1;
      if (out_ready && t >= pend + 1 && !done1) done1 = 1;
      ev_prev = ev;
    end
    nchk++;
    if (!(done0 && done1)) begin
      nerr++; $display("FAIL encode_timeout: done0=%b done1=%b required 1", done0, done1);
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'($urandom_range(1)); out_ready = 1'($urandom_range(1));
    #1;
    nchk++;
    if (obs0 !== {11'b0, 2'(z), 9'b0} || obs1 !== {11'b0, 2'(z), 9'b0}) begin
      nerr++; $display("FAIL back_to_idle: lut=%h bram=%h required %h", obs0, obs1, {11'b0, 2'(z), 9'b0});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; req_z = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
    #3;
    nchk++;
    if (obs0 !== 20'h0 || obs1 !== 20'h0) begin
      nerr++; $display("FAIL reset_state: lut=%h bram=%h required 00000", obs0, obs1);
    end
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_contiguous();
    int na, np;
    run_encode(2, 100, 0, 0, na, np);
  endtask

  task automatic test_gaps();
    int na, np;
    run_encode(0, 50, 0, 0, na, np);
    nchk++;
    if (na != IB) begin nerr++; $display("FAIL acc_en_count: got %0d required %0d", na, IB); end
    nchk++;
    if (np != NP) begin nerr++; $display("FAIL par_en_count: got %0d required %0d", np, NP); end
  endtask

  task automatic test_cfg_err();
    logic [2:0] bad [2] = '{3'b011, 3'b000};
    foreach (bad[k]) begin
      @(negedge clk); start = 1'b1; req_z = bad[k]; in_valid = 1'b1;
      @(negedge clk); start = 1'b0; req_z = 3'b001;
      #1;
      nchk++;
      if ({cfg0, busy0, ir0} !== 3'b100 || {cfg1, busy1, ir1} !== 3'b100) begin
        nerr++; $display("FAIL cfg_err_pulse req_z=%b: lut=%b bram=%b required 100", bad[k],
                         {cfg0, busy0, ir0}, {cfg1, busy1, ir1});
      end
      @(negedge clk);
      #1;
      nchk++;
      if ({cfg0, busy0, ir0} !== 3'b000 || {cfg1, busy1, ir1} !== 3'b000) begin
        nerr++; $display("FAIL cfg_err_clear req_z=%b: lut=%b bram=%b required 000", bad[k],
                         {cfg0, busy0, ir0}, {cfg1, busy1, ir1});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_out_stall();
    int na, np;
    run_encode(1, 70, 5, 1, na, np);
    run_encode(2, 80, 0, 0, na, np);
  endtask

  task automatic test_reset_mid();
    int na, np;
    @(negedge clk); start = 1'b1; req_z = 3'b001; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (obs0 !== 20'h0 || obs1 !== 20'h0) begin
      nerr++; $display("FAIL reset_mid: lut=%h bram=%h required 00000", obs0, obs1);
    end
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      nerr++; $display("FAIL reset_hold: ov=%b%b busy=%b%b required 0", ov0, ov1, busy0, busy1);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    run_encode(0, 100, 0, 0, na, np);
  endtask

  task automatic test_random();
    int na, np;
    for (int i = 0; i < 6; i++) begin
      run_encode(int'($urandom_range(2)), int'($urandom_range(95, 20)),
                 int'($urandom_range(3)), 1'b0, na, np);
      nchk++;
      if (na != IB || np != NP) begin
        nerr++; $display("FAIL random_counts: acc=%0d par=%0d required %0d %0d", na, np, IB, NP);
      end
    end
  endtask

  task automatic test_back_to_back();
    int na, np;
    run_encode(1, 100, 0, 0, na, np);
    run_encode(0, 100, 2, 1, na, np);
  endtask

  initial begin
    nchk = 0; nerr = 0;
    test_reset();
    test_contiguous();
    test_gaps();
    test_cfg_err();
    test_out_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
